voting_session_ctrl: RTL
========================

Name: voting_session_ctrl

Overview:
- Session controller and booth arbiter in front of voting_machine.
- Collects ballot requests from N_BOOTHS booths and enforces one vote per armed voter.
- Serialises accepted votes round-robin into single-cycle i_candidate_1/2/3 pulses with a guaranteed idle gap.
- Runs the IDLE/OPEN/CLOSING/CLOSED session FSM that drives i_voting_over.

Parameters:
- N_BOOTHS, 4, number of requesting booths (2..8).
- CNT_W, 6, width of the accepted-ballot total; matches the voting_machine count width.
- GAP, 1, minimum low cycles between consecutive candidate pulses (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  officer opens session (level, sampled).
- i_close  in  1  officer closes session (level, sampled).
- i_arm  in  N_BOOTHS  per-booth arm; authorises one ballot.
- i_booth_req  in  N_BOOTHS  per-booth ballot request (level).
- i_booth_sel  in  2*N_BOOTHS  candidate code per booth, booth b at [2b+1:2b]; 1..3 valid, 0 invalid.
- o_booth_ack  out  N_BOOTHS  one-cycle accept pulse.
- o_booth_nack  out  N_BOOTHS  one-cycle reject pulse.
- o_cand1, o_cand2, o_cand3  out  1 each  one-cycle vote pulses to voting_machine.
- o_voting_over  out  1  to voting_machine i_voting_over.
- o_state  out  2  FSM state: 0 IDLE, 1 OPEN, 2 CLOSING, 3 CLOSED.
- o_total  out  CNT_W  accepted ballots this session.
- o_armed  out  N_BOOTHS  current armed bits.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; armed=0; rr pointer=0; gap counter=0.
- All outputs are registered.
- Response latency: a req sampled at edge k produces ack/nack and any o_candX at edge k+1, all for exactly one cycle.
- Handshake:
  - A booth holds req until it sees ack or nack, then drops it.
  - The controller masks that booth for the one cycle after its response, so a late drop produces no second response.
- IDLE:
  - All requests are nacked. i_arm is ignored.
  - i_start -> OPEN.
- OPEN:
  - i_arm[b] sets armed[b].
  - Eligible booth: req=1, not masked, armed=1, sel!=0, and o_total < 2^CNT_W-1.
  - Immediate nack, no arbitration, all in the same cycle: req from a booth that is unarmed, has sel=0, or arrives while o_total is saturated.
  - Grant rule: when the gap counter is 0 and ≥1 booth is eligible, grant exactly one, searching from the rr pointer upward with wrap.
  - On grant to booth b:
    - ack[b]=1 and armed[b] cleared.
    - o_cand(sel[b])=1, and o_total increments.
    - rr pointer = (b+1) mod N_BOOTHS; gap counter loads GAP.
  - Eligible booths that are not granted receive no response and keep waiting.
  - Gap counter decrements each cycle while non-zero; no grant while it is non-zero.
  - Same-cycle grant and i_arm to the same booth: the grant clear wins, so armed=0.
  - i_close -> CLOSING; it takes priority over any grant in that cycle, so no new grant is issued.
- CLOSING:
  - All requests are nacked.
  - Stay until the gap counter reaches 0, then -> CLOSED.
  - With gap=0 on entry, CLOSING lasts exactly one cycle.
- CLOSED:
  - o_voting_over=1 held; armed cleared on entry; all requests nacked.
  - i_start and i_close are ignored. Exit only via rst.
- Simultaneous i_start and i_close: in IDLE, start wins -> OPEN; in OPEN, close wins.
- At most one o_candX is high in any cycle. o_candX is never high in two consecutive cycles.
- Reset mid-pulse clears o_candX immediately (async). voting_machine is reset by the same rst, so its counts stay consistent.

Decomposition:
- Shared package voting_pkg:
  - state enum (IDLE/OPEN/CLOSING/CLOSED, 2-bit).
  - candidate code constants CAND_NONE=0, CAND_1=1, CAND_2=2, CAND_3=3.
  - default CNT_W.
- Sub-module rr_arbiter (N-bit eligible vector plus pointer in; one-hot grant plus grant index out; purely combinational). The FSM, gap counter, armed bits, and total stay in voting_session_ctrl.

Test Plan:
- Reset, i_start, arm booth 0, req sel=1 -> next cycle ack[0]=1 and o_cand1=1 for one cycle; o_total=1; o_armed[0]=0.
- Booth 2 requests while unarmed -> nack[2] one cycle later; no o_candX; o_total unchanged.
- Booths 0..3 all armed, each sel=2, req together, GAP=1 -> acks in order 0,1,2,3 on every second cycle; o_cand2 pulses four times; o_total=4.
- Arm booth 1, req sel=0 -> nack[1]; armed[1] stays 1. Re-request with sel=3 -> ack and o_cand3.
- i_close asserted the cycle a pulse issues -> one CLOSING cycle after the gap expires, then o_state=3 and o_voting_over=1. Later req -> nack; i_start ignored.
- Preload 63 accepted votes, then one more armed req -> nack, o_total stays 63. Assert rst mid-session -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and constants for the voting session controller and its arbiter.
package voting_pkg;

  // Session FSM encoding, also driven out on o_state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_CLOSING = 2'd2,
    ST_CLOSED  = 2'd3
  } state_e;

  // Candidate codes carried on each booth's select field.
  localparam logic [1:0] CAND_NONE = 2'd0;
  localparam logic [1:0] CAND_1    = 2'd1;
  localparam logic [1:0] CAND_2    = 2'd2;
  localparam logic [1:0] CAND_3    = 2'd3;

  // Ballot total width, matching the voting_machine count width.
  localparam int CNT_W_DEF = 6;

  // Width of the inter-pulse gap counter (GAP is limited to 1..7).
  localparam int GAP_W = 3;

  // A select code names a real candidate unless it is CAND_NONE.
  function automatic logic is_valid_cand(input logic [1:0] code);
    return (code != CAND_NONE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or
// above the pointer, wrapping around, and reports it one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found_s;
  int   pos_s;

  // Scan N positions starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    pos_s     = 0;
    for (int i = 0; i < N; i++) begin
      pos_s = int'(ptr) + i;
      if (pos_s >= N) begin
        pos_s = pos_s - N;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && elig[pos_s[IW-1:0]]) begin
        grant[pos_s[IW-1:0]] = 1'b1;
        grant_idx            = pos_s[IW-1:0];
        found_s              = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/voting_session_ctrl.sv
// Session controller and booth arbiter in front of voting_machine. Accepts one
// ballot per armed voter, serialises accepted ballots into spaced single-cycle
// candidate pulses, and runs the IDLE/OPEN/CLOSING/CLOSED session FSM.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int N_BOOTHS = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int GAP      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_close,
  input  logic [N_BOOTHS-1:0]     i_arm,
  input  logic [N_BOOTHS-1:0]     i_booth_req,
  input  logic [2*N_BOOTHS-1:0]   i_booth_sel,
  output logic [N_BOOTHS-1:0]     o_booth_ack,
  output logic [N_BOOTHS-1:0]     o_booth_nack,
  output logic                    o_cand1,
  output logic                    o_cand2,
  output logic                    o_cand3,
  output logic                    o_voting_over,
  output logic [1:0]              o_state,
  output logic [CNT_W-1:0]        o_total,
  output logic [N_BOOTHS-1:0]     o_armed
);

  localparam int IW = $clog2(N_BOOTHS);

  // Registered state and outputs
  state_e                state_r;
  logic [N_BOOTHS-1:0]   armed_r;
  logic [N_BOOTHS-1:0]   mask_r;
  logic [N_BOOTHS-1:0]   ack_r;
  logic [N_BOOTHS-1:0]   nack_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [GAP_W-1:0]      gap_r;
  logic [CNT_W-1:0]      total_r;
  logic                  cand1_r;
  logic                  cand2_r;
  logic                  cand3_r;
  logic                  voting_over_r;

  // Combinational decode
  logic [N_BOOTHS-1:0]   live_req_s;
  logic [N_BOOTHS-1:0]   sel_ok_s;
  logic [N_BOOTHS-1:0]   elig_s;
  logic [N_BOOTHS-1:0]   arb_grant_s;
  logic [IW-1:0]         arb_idx_s;
  logic [N_BOOTHS-1:0]   grant_s;
  logic [N_BOOTHS-1:0]   nack_s;
  logic                  sat_s;
  logic                  grant_en_s;
  logic [1:0]            code_s;
  logic [IW-1:0]         ptr_next_s;
  logic [GAP_W-1:0]      gap_next_s;

  // A booth that was answered last cycle is ignored for one cycle so that a
  // request dropped one cycle late is not answered twice.
  assign live_req_s = i_booth_req & ~mask_r;
  assign sat_s      = (total_r == {CNT_W{1'b1}});

  for (genvar g = 0; g < N_BOOTHS; g++) begin : g_sel
    assign sel_ok_s[g] = is_valid_cand(i_booth_sel[2*g +: 2]);
  end

  assign elig_s = live_req_s & armed_r & sel_ok_s & {N_BOOTHS{~sat_s}};

  rr_arbiter #(
    .N  (N_BOOTHS),
    .IW (IW)
  ) u_arb (
    .elig      (elig_s),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Grant only in OPEN, with the gap expired, and never in a closing cycle.
  always_comb begin
    grant_en_s = 1'b0;
    if ((state_r == ST_OPEN) && !i_close && (gap_r == {GAP_W{1'b0}}) && (|elig_s)) begin
      grant_en_s = 1'b1;
    end else begin
      grant_en_s = 1'b0;
    end
  end

  assign grant_s = grant_en_s ? arb_grant_s : {N_BOOTHS{1'b0}};
  assign code_s  = i_booth_sel[{arb_idx_s, 1'b0} +: 2];

  // Next round-robin pointer: the booth just above the granted one, wrapping.
  always_comb begin
    ptr_next_s = '0;
    if (arb_idx_s == IW'(N_BOOTHS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = arb_idx_s + IW'(1);
    end
  end

  // Gap counter reloads on a grant and otherwise counts down to zero.
  always_comb begin
    gap_next_s = gap_r;
    if (grant_en_s) begin
      gap_next_s = GAP_W'(GAP);
    end else if (gap_r != {GAP_W{1'b0}}) begin
      gap_next_s = gap_r - GAP_W'(1);
    end else begin
      gap_next_s = gap_r;
    end
  end

  // Rejections: everything outside OPEN; inside OPEN only requests that can
  // never be served (unarmed, no candidate, or total saturated).
  always_comb begin
    nack_s = '0;
    case (state_r)
      ST_OPEN:    nack_s = live_req_s & ~elig_s;
      ST_IDLE:    nack_s = live_req_s;
      ST_CLOSING: nack_s = live_req_s;
      ST_CLOSED:  nack_s = live_req_s;
      default:    nack_s = live_req_s;
    endcase
  end

  // Session FSM together with all registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      armed_r       <= '0;
      mask_r        <= '0;
      ack_r         <= '0;
      nack_r        <= '0;
      rr_ptr_r      <= '0;
      gap_r         <= '0;
      total_r       <= '0;
      cand1_r       <= 1'b0;
      cand2_r       <= 1'b0;
      cand3_r       <= 1'b0;
      voting_over_r <= 1'b0;
    end else begin
      ack_r   <= grant_s;
      nack_r  <= nack_s;
      mask_r  <= grant_s | nack_s;
      cand1_r <= grant_en_s && (code_s == CAND_1);
      cand2_r <= grant_en_s && (code_s == CAND_2);
      cand3_r <= grant_en_s && (code_s == CAND_3);
      gap_r   <= gap_next_s;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          // The grant clear overrides a same-cycle arm of the granted booth.
          armed_r <= (armed_r | i_arm) & ~grant_s;
          if (grant_en_s) begin
            total_r  <= total_r + CNT_W'(1);
            rr_ptr_r <= ptr_next_s;
          end
          if (i_close) begin
            state_r <= ST_CLOSING;
          end
        end
        ST_CLOSING: begin
          // Let the last pulse's gap drain before reporting the session over.
          if (gap_r == {GAP_W{1'b0}}) begin
            state_r       <= ST_CLOSED;
            armed_r       <= '0;
            voting_over_r <= 1'b1;
          end
        end
        ST_CLOSED: begin
          voting_over_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_booth_ack   = ack_r;
  assign o_booth_nack  = nack_r;
  assign o_cand1       = cand1_r;
  assign o_cand2       = cand2_r;
  assign o_cand3       = cand3_r;
  assign o_voting_over = voting_over_r;
  assign o_state       = state_r;
  assign o_total       = total_r;
  assign o_armed       = armed_r;

endmodule
